// File: rtl/rc5_key_scheduler.sv
// RC5 key-expansion sequencer: loads L, ramps S, runs the mixer,
// then hands the S table to the cipher core through one shared port.
module rc5_key_scheduler #(
    parameter int          W           = 32,
    parameter int          C           = 4,
    parameter int          T           = 26,
    parameter logic [31:0] P           = 32'hB7E15163,
    parameter logic [31:0] Q           = 32'h9E3779B9,
    parameter int          MIX_TIMEOUT = 1024,
    localparam int         SAW         = $clog2(T),
    localparam int         TW          = $clog2(MIX_TIMEOUT + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           iKeyValid,
    input  logic [W-1:0]   iKeyWord,
    output logic           oKeyReady,
    output logic           oMixRst,
    output logic           oMixStart,
    input  logic           iMixDone,
    input  logic [SAW-1:0] iMixS_address,
    input  logic [W-1:0]   iMixS_data,
    input  logic [W-1:0]   iMixL_data,
    input  logic           iMixS_we,
    input  logic           iMixL_we,
    input  logic [1:0]     iMixL_address,
    output logic [SAW-1:0] oS_address,
    output logic [W-1:0]   oS_wdata,
    output logic           oS_we,
    output logic [1:0]     oL_address,
    output logic [W-1:0]   oL_wdata,
    output logic           oL_we,
    input  logic           iCipherReq,
    input  logic [SAW-1:0] iCipherAddr,
    output logic           oCipherGrant,
    output logic           oScheduleDone,
    output logic           oError
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_L,
        INIT_S,
        MIX_RST,
        MIX_START,
        MIX_WAIT,
        READY
    } state_t;

    state_t         state, stateN;
    logic [1:0]     kcnt, kcntN;
    logic [SAW-1:0] icnt, icntN;
    logic [W-1:0]   acc, accN;
    logic [TW-1:0]  tcnt, tcntN;
    logic           err, errN;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            kcnt  <= '0;
            icnt  <= '0;
            acc   <= '0;
            tcnt  <= '0;
            err   <= 1'b0;
        end else begin
            state <= stateN;
            kcnt  <= kcntN;
            icnt  <= icntN;
            acc   <= accN;
            tcnt  <= tcntN;
            err   <= errN;
        end
    end

    // Port drive is suppressed while rst is high so a reset never leaks a write.
    always_comb begin
        stateN        = state;
        kcntN         = kcnt;
        icntN         = icnt;
        accN          = acc;
        tcntN         = tcnt;
        errN          = err;
        oKeyReady     = 1'b0;
        oMixStart     = 1'b0;
        oS_address    = '0;
        oS_wdata      = '0;
        oS_we         = 1'b0;
        oL_address    = '0;
        oL_wdata      = '0;
        oL_we         = 1'b0;
        oCipherGrant  = 1'b0;
        oScheduleDone = 1'b0;
        oError        = err;
        oMixRst       = rst || (state == MIX_RST);
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    oKeyReady = 1'b1;
                    if (iKeyValid) begin
                        oL_we    = 1'b1;
                        oL_wdata = iKeyWord;
                        kcntN    = 2'd1;
                        errN     = 1'b0;
                        stateN   = LOAD_L;
                    end
                end
                LOAD_L: begin
                    oKeyReady = 1'b1;
                    if (iKeyValid) begin
                        oL_we      = 1'b1;
                        oL_address = kcnt;
                        oL_wdata   = iKeyWord;
                        kcntN      = kcnt + 2'd1;
                        if (kcnt == 2'(C - 1)) begin
                            icntN  = '0;
                            accN   = W'(P);
                            stateN = INIT_S;
                        end
                    end
                end
                INIT_S: begin
                    oS_we      = 1'b1;
                    oS_address = icnt;
                    oS_wdata   = acc;
                    accN       = acc + W'(Q);
                    icntN      = icnt + 1'b1;
                    if (icnt == SAW'(T - 1))
                        stateN = MIX_RST;
                end
                MIX_RST: stateN = MIX_START;
                MIX_START: begin
                    oMixStart = 1'b1;
                    tcntN     = '0;
                    stateN    = MIX_WAIT;
                end
                MIX_WAIT: begin
                    oS_address = iMixS_address;
                    oS_wdata   = iMixS_data;
                    oS_we      = iMixS_we;
                    oL_address = iMixL_address;
                    oL_wdata   = iMixL_data;
                    oL_we      = iMixL_we;
                    tcntN      = tcnt + 1'b1;
                    if (iMixDone) begin
                        stateN = READY;
                    end else if (tcnt == TW'(MIX_TIMEOUT - 1)) begin
                        errN   = 1'b1;
                        stateN = IDLE;
                    end
                end
                READY: begin
                    oScheduleDone = 1'b1;
                    oKeyReady     = 1'b1;
                    oS_address    = iCipherAddr;
                    if (iKeyValid) begin
                        oL_we    = 1'b1;
                        oL_wdata = iKeyWord;
                        kcntN    = 2'd1;
                        stateN   = LOAD_L;
                    end else begin
                        oCipherGrant = iCipherReq;
                    end
                end
                default: stateN = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rc5_key_scheduler.sv
// Scoreboard bench for rc5_key_scheduler: expected S/L writes are queued
// by the stimulus and popped by a monitor on every observed write.
module tb_rc5_key_scheduler;

    localparam int W = 32;
    localparam int SAW = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic           iKeyValid;
    logic [W-1:0]   iKeyWord;
    logic           oKeyReady;
    logic           oMixRst;
    logic           oMixStart;
    logic           iMixDone;
    logic [SAW-1:0] iMixS_address;
    logic [W-1:0]   iMixS_data;
    logic [W-1:0]   iMixL_data;
    logic           iMixS_we;
    logic           iMixL_we;
    logic [1:0]     iMixL_address;
    logic [SAW-1:0] oS_address;
    logic [W-1:0]   oS_wdata;
    logic           oS_we;
    logic [1:0]     oL_address;
    logic [W-1:0]   oL_wdata;
    logic           oL_we;
    logic           iCipherReq;
    logic [SAW-1:0] iCipherAddr;
    logic           oCipherGrant;
    logic           oScheduleDone;
    logic           oError;

    rc5_key_scheduler #(.MIX_TIMEOUT(16)) dut (
        .clk(clk),
        .rst(rst),
        .iKeyValid(iKeyValid),
        .iKeyWord(iKeyWord),
        .oKeyReady(oKeyReady),
        .oMixRst(oMixRst),
        .oMixStart(oMixStart),
        .iMixDone(iMixDone),
        .iMixS_address(iMixS_address),
        .iMixS_data(iMixS_data),
        .iMixL_data(iMixL_data),
        .iMixS_we(iMixS_we),
        .iMixL_we(iMixL_we),
        .iMixL_address(iMixL_address),
        .oS_address(oS_address),
        .oS_wdata(oS_wdata),
        .oS_we(oS_we),
        .oL_address(oL_address),
        .oL_wdata(oL_wdata),
        .oL_we(oL_we),
        .iCipherReq(iCipherReq),
        .iCipherAddr(iCipherAddr),
        .oCipherGrant(oCipherGrant),
        .oScheduleDone(oScheduleDone),
        .oError(oError)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         sq[$];
    wr_t         lq[$];
    int          nVec = 0;
    int          nErr = 0;
    logic [31:0] key[4];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Hand-computed ramp points; the rest follow P + i*Q.
    function automatic logic [31:0] expS(input int i);
        case (i)
            0:       return 32'hB7E15163;
            1:       return 32'h5618CB1C;
            2:       return 32'hF45044D5;
            25:      return 32'h2B4C3474;
            default: return 32'hB7E15163 + 32'(i) * 32'h9E3779B9;
        endcase
    endfunction

    task automatic pushS(input int a, input logic [31:0] d);
        wr_t e;
        e.addr = 5'(a);
        e.data = d;
        sq.push_back(e);
    endtask

    task automatic pushL(input int a, input logic [31:0] d);
        wr_t e;
        e.addr = 5'(a);
        e.data = d;
        lq.push_back(e);
    endtask

    task automatic monitor();
        wr_t e;
        forever begin
            @(negedge clk);
            if (oS_we === 1'b1) begin
                if (sq.size() == 0) begin
                    nVec++;
                    nErr++;
                    $display("FAIL sWrUnexpected: got S[%0d]=%h, required no write",
                             oS_address, oS_wdata);
                end else begin
                    e = sq.pop_front();
                    chk("sWrAddr", 32'(oS_address), 32'(e.addr));
                    chk("sWrData", oS_wdata, e.data);
                end
            end
            if (oL_we === 1'b1) begin
                if (lq.size() == 0) begin
                    nVec++;
                    nErr++;
                    $display("FAIL lWrUnexpected: got L[%0d]=%h, required no write",
                             oL_address, oL_wdata);
                end else begin
                    e = lq.pop_front();
                    chk("lWrAddr", 32'(oL_address), 32'(e.addr));
                    chk("lWrData", oL_wdata, e.data);
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic loadKey();
        for (int k = 0; k < 4; k++) begin
            pushL(k, key[k]);
            iKeyValid = 1'b1;
            iKeyWord  = key[k];
            @(negedge clk);
            chk("keyReady", 32'(oKeyReady), 32'd1);
            tick();
        end
        iKeyValid = 1'b0;
        iKeyWord  = '0;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        iKeyValid = 1'b0;
        iKeyWord = '0;
        iMixDone = 1'b0;
        iMixS_address = '0;
        iMixS_data = '0;
        iMixL_data = '0;
        iMixS_we = 1'b0;
        iMixL_we = 1'b0;
        iMixL_address = '0;
        iCipherReq = 1'b0;
        iCipherAddr = '0;
        fork
            monitor();
        join_none

        tick();
        tick();
        @(negedge clk);
        chk("mixRstInReset", 32'(oMixRst), 32'd1);
        rst = 1'b0;
        tick();
        @(negedge clk);
        chk("rstKeyReady", 32'(oKeyReady), 32'd1);
        chk("rstDone", 32'(oScheduleDone), 32'd0);
        chk("rstError", 32'(oError), 32'd0);
        chk("rstMixStart", 32'(oMixStart), 32'd0);
        chk("rstMixRst", 32'(oMixRst), 32'd0);
        chk("rstGrant", 32'(oCipherGrant), 32'd0);
        chk("rstSWe", 32'(oS_we), 32'd0);
        tick();

        // zero key, full init, mixer handshake
        for (int i = 0; i < 26; i++) pushS(i, expS(i));
        for (int k = 0; k < 4; k++) key[k] = '0;
        loadKey();
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            chk("initWe", 32'(oS_we), 32'd1);
            tick();
        end
        @(negedge clk);
        chk("initEndWe", 32'(oS_we), 32'd0);
        chk("mixRstPulse", 32'(oMixRst), 32'd1);
        chk("mixStartEarly", 32'(oMixStart), 32'd0);
        tick();
        @(negedge clk);
        chk("mixStartPulse", 32'(oMixStart), 32'd1);
        chk("mixRstAfter", 32'(oMixRst), 32'd0);
        tick();
        iMixL_we = 1'b1;
        iMixL_address = 2'd2;
        iMixL_data = 32'hA5A55A5A;
        pushL(2, 32'hA5A55A5A);
        @(negedge clk);
        chk("mixStartOnce", 32'(oMixStart), 32'd0);
        chk("waitKeyReady", 32'(oKeyReady), 32'd0);
        tick();
        iMixL_we = 1'b0;
        iMixS_we = 1'b1;
        iMixS_address = 5'd5;
        iMixS_data = 32'hDEADBEEF;
        iMixDone = 1'b1;
        pushS(5, 32'hDEADBEEF);
        @(negedge clk);
        chk("doneCycleNotReady", 32'(oScheduleDone), 32'd0);
        tick();
        iMixS_we = 1'b0;
        iMixS_address = '0;
        iMixS_data = '0;
        iMixDone = 1'b0;
        iCipherReq = 1'b1;
        iCipherAddr = 5'd7;
        @(negedge clk);
        chk("schedDone", 32'(oScheduleDone), 32'd1);
        chk("cipherAddr", 32'(oS_address), 32'd7);
        chk("cipherGrant", 32'(oCipherGrant), 32'd1);
        chk("cipherNoWe", 32'(oS_we), 32'd0);
        tick();

        // re-key beats cipher request, then stalled key load 1,0,1,0,1,1
        iKeyValid = 1'b1;
        iKeyWord = 32'h11111111;
        pushL(0, 32'h11111111);
        @(negedge clk);
        chk("rekeyGrant", 32'(oCipherGrant), 32'd0);
        tick();
        iCipherReq = 1'b0;
        iKeyValid = 1'b0;
        iKeyWord = 32'hBADBAD00;
        @(negedge clk);
        chk("rekeyDoneDrop", 32'(oScheduleDone), 32'd0);
        chk("rekeyKeyReady", 32'(oKeyReady), 32'd1);
        tick();
        iKeyValid = 1'b1;
        iKeyWord = 32'h22222222;
        pushL(1, 32'h22222222);
        @(negedge clk);
        tick();
        iKeyValid = 1'b0;
        iKeyWord = 32'hBADBAD01;
        @(negedge clk);
        chk("stallNoInit", 32'(oS_we), 32'd0);
        tick();
        iKeyValid = 1'b1;
        iKeyWord = 32'h33333333;
        pushL(2, 32'h33333333);
        @(negedge clk);
        tick();
        iKeyWord = 32'h44444444;
        pushL(3, 32'h44444444);
        for (int i = 0; i < 10; i++) pushS(i, expS(i));
        @(negedge clk);
        chk("lastWordNoInit", 32'(oS_we), 32'd0);
        tick();
        iKeyValid = 1'b0;
        iKeyWord = '0;
        @(negedge clk);
        chk("firstSWe", 32'(oS_we), 32'd1);
        chk("firstSAddr", 32'(oS_address), 32'd0);
        tick();
        for (int i = 1; i < 10; i++) begin
            @(negedge clk);
            tick();
        end

        // reset at icnt=10
        rst = 1'b1;
        @(negedge clk);
        chk("midRstMixRst", 32'(oMixRst), 32'd1);
        chk("midRstNoSWe", 32'(oS_we), 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("postRstKeyReady", 32'(oKeyReady), 32'd1);
            chk("postRstNoSWe", 32'(oS_we), 32'd0);
            tick();
        end

        // mixer timeout
        key[0] = 32'h01234567;
        key[1] = 32'h89ABCDEF;
        key[2] = 32'hFEDCBA98;
        key[3] = 32'h76543210;
        for (int i = 0; i < 26; i++) pushS(i, expS(i));
        loadKey();
        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            tick();
        end
        @(negedge clk);
        chk("toMixStart", 32'(oMixStart), 32'd1);
        tick();
        n = 0;
        while (n < 64) begin
            @(negedge clk);
            if (oKeyReady === 1'b1) break;
            n++;
            tick();
        end
        chk("timeoutCycles", 32'(n), 32'd16);
        chk("timeoutError", 32'(oError), 32'd1);
        chk("timeoutDone", 32'(oScheduleDone), 32'd0);
        tick();
        iKeyValid = 1'b1;
        iKeyWord = 32'hCAFEF00D;
        pushL(0, 32'hCAFEF00D);
        @(negedge clk);
        chk("errorSticky", 32'(oError), 32'd1);
        tick();
        iKeyValid = 1'b0;
        iKeyWord = '0;
        @(negedge clk);
        chk("errorCleared", 32'(oError), 32'd0);
        tick();
        repeat (3) tick();

        chk("sQueueDrained", 32'(sq.size()), 32'd0);
        chk("lQueueDrained", 32'(lq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
